// File: rtl/logic_unit_arbiter_pkg.sv
// Shared types for the round-robin logic-unit arbiter: opcodes and FSM states.
package logic_arb_pkg;

    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_NAND = 2'b11
    } logic_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        HOLD = 2'b10
    } arb_state_e;

endpackage

// File: rtl/logic_unit_arbiter_if.sv
// Request/response bundle between the requesters, the arbiter and the result consumer.
// The rsp_zero signal exists only when LOGIC_ARB_ZERO_FLAG_EN is defined.
interface logic_unit_arbiter_if
    import logic_arb_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0][WIDTH-1:0] req_a;
    logic [NUM_REQ-1:0][WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0][OP_W-1:0]  req_op;
    logic                          rsp_valid;
    logic                          rsp_ready;
    logic [ID_W-1:0]               rsp_id;
    logic [WIDTH-1:0]              rsp_result;
`ifdef LOGIC_ARB_ZERO_FLAG_EN
    logic                          rsp_zero;
`endif

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result
`ifdef LOGIC_ARB_ZERO_FLAG_EN
        , input rsp_zero
`endif
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result
`ifdef LOGIC_ARB_ZERO_FLAG_EN
        , output rsp_zero
`endif
    );
endinterface

// File: rtl/logic_unit_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request strictly after last_grant, with wrap.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               any_req
);

    logic [ID_W-1:0] idx;
    logic            found;

    // Scanning offsets 1..NUM_REQ visits last_grant itself last, which gives the fairness bound.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = ID_W'((int'(last_grant) + i) % NUM_REQ);
            if (!found && req[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                grant_id    = idx;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/logic_unit_arbiter.sv
// Shared registered 4-bit logic unit with round-robin arbitration over NUM_REQ requesters.
// Define LOGIC_ARB_ZERO_FLAG_EN to add the registered rsp_zero flag.
module logic_unit_arbiter
    import logic_arb_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    logic_unit_arbiter_if.slave  bus
);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic               any_req;
    logic [ID_W-1:0]    last_grant_q;
    logic [ID_W-1:0]    owner_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic_op_e          op_q;
    logic [WIDTH-1:0]   exec_result;
    logic               rsp_valid_q;
    logic [ID_W-1:0]    rsp_id_q;
    logic [WIDTH-1:0]   rsp_result_q;
`ifdef LOGIC_ARB_ZERO_FLAG_EN
    logic               rsp_zero_q;
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .req        (bus.req_valid),
        .last_grant (last_grant_q),
        .grant      (grant),
        .grant_id   (grant_id),
        .any_req    (any_req)
    );

    always_comb begin
        exec_result = '0;
        case (op_q)
            OP_AND:  exec_result = a_q & b_q;
            OP_OR:   exec_result = a_q | b_q;
            OP_XOR:  exec_result = a_q ^ b_q;
            OP_NAND: exec_result = ~(a_q & b_q);
            default: exec_result = '0;
        endcase
    end

    // Grants are only offered in IDLE, so req_ready is one-hot or zero by construction.
    always_comb begin
        state_d       = state_q;
        bus.req_ready = '0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    bus.req_ready = grant;
                    state_d       = EXEC;
                end
            end
            EXEC: state_d = HOLD;
            HOLD: begin
                if (rsp_valid_q && bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            owner_q      <= '0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= OP_AND;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
`ifdef LOGIC_ARB_ZERO_FLAG_EN
            rsp_zero_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        a_q          <= bus.req_a[grant_id];
                        b_q          <= bus.req_b[grant_id];
                        op_q         <= logic_op_e'(bus.req_op[grant_id]);
                        owner_q      <= grant_id;
                        last_grant_q <= grant_id;
                    end
                end
                EXEC: begin
                    rsp_result_q <= exec_result;
                    rsp_id_q     <= owner_q;
                    rsp_valid_q  <= 1'b1;
`ifdef LOGIC_ARB_ZERO_FLAG_EN
                    rsp_zero_q   <= (exec_result == '0);
`endif
                end
                HOLD: begin
                    if (rsp_valid_q && bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
`ifdef LOGIC_ARB_ZERO_FLAG_EN
    assign bus.rsp_zero   = rsp_zero_q;
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Testbench for logic_unit_arbiter: vector table, directed corner sequences and a random run
// against a transaction-level model. Zero-flag checks follow LOGIC_ARB_ZERO_FLAG_EN.
module tb_logic_unit_arbiter;
    import logic_arb_pkg::*;

    localparam int WIDTH   = 4;
    localparam int NUM_REQ = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic_unit_arbiter_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) bus ();

    logic_unit_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         r;
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] res;
        logic       z;
    } vec_t;

    typedef struct {
        int         id;
        logic [3:0] res;
    } exp_t;

    vec_t vecs [10];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Reference behaviour of the logic unit taken straight from the opcode table.
    function automatic logic [3:0] refOp(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [3:0] r;
        case (op)
            2'b00:   r = a & b;
            2'b01:   r = a | b;
            2'b10:   r = a ^ b;
            default: r = ~(a & b);
        endcase
        return r;
    endfunction

    task automatic idleInputs();
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = '0;
        bus.rsp_ready = 1'b1;
    endtask

    task automatic doReset();
        @(posedge clk); #1;
        rst = 1'b1;
        idleInputs();
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic checkZero(input string name, input logic expected);
`ifdef LOGIC_ARB_ZERO_FLAG_EN
        checkOutput(name, 32'(bus.rsp_zero), 32'(expected));
`endif
    endtask

    // One isolated transaction with rsp_ready held high; caller is at posedge+1 with the DUT idle.
    task automatic applyStimulus(input vec_t v);
        bus.req_valid        = '0;
        bus.req_valid[v.r]   = 1'b1;
        bus.req_a[v.r]       = v.a;
        bus.req_b[v.r]       = v.b;
        bus.req_op[v.r]      = v.op;
        bus.rsp_ready        = 1'b1;
        @(negedge clk);
        checkOutput("vec_accept", 32'(bus.req_ready), 32'(1 << v.r));
        @(posedge clk); #1;
        bus.req_valid = '0;
        @(negedge clk);
        checkOutput("vec_exec_valid", 32'(bus.rsp_valid), 32'(0));
        checkOutput("vec_exec_ready", 32'(bus.req_ready), 32'(0));
        @(negedge clk);
        checkOutput("vec_rsp_valid", 32'(bus.rsp_valid), 32'(1));
        checkOutput("vec_rsp_result", 32'(bus.rsp_result), 32'(v.res));
        checkOutput("vec_rsp_id", 32'(bus.rsp_id), 32'(v.r));
        checkZero("vec_rsp_zero", v.z);
        @(negedge clk);
        checkOutput("vec_rsp_drop", 32'(bus.rsp_valid), 32'(0));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog expired actual=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int ng, nr, lastc;
        logic        pv [NUM_REQ];
        logic [3:0]  pa [NUM_REQ];
        logic [3:0]  pb [NUM_REQ];
        logic [1:0]  po [NUM_REQ];
        exp_t        q [$];
        exp_t        e;
        int          last_ptr, acc_c, eg, idx;
        bit          outstanding, was_out, ev, rr_drv;

        vecs[0] = '{0, 2'b00, 4'b1000, 4'b1010, 4'b1000, 1'b0};
        vecs[1] = '{1, 2'b01, 4'b1110, 4'b1011, 4'b1111, 1'b0};
        vecs[2] = '{0, 2'b10, 4'b1011, 4'b1100, 4'b0111, 1'b0};
        vecs[3] = '{1, 2'b11, 4'b0111, 4'b1000, 4'b1111, 1'b0};
        vecs[4] = '{0, 2'b00, 4'b0101, 4'b1010, 4'b0000, 1'b1};
        vecs[5] = '{0, 2'b01, 4'b0101, 4'b1010, 4'b1111, 1'b0};
        vecs[6] = '{1, 2'b10, 4'b1111, 4'b1111, 4'b0000, 1'b1};
        vecs[7] = '{1, 2'b11, 4'b1111, 4'b1111, 4'b0000, 1'b1};
        vecs[8] = '{0, 2'b11, 4'b0000, 4'b0000, 4'b1111, 1'b0};
        vecs[9] = '{1, 2'b00, 4'b0110, 4'b0011, 4'b0010, 1'b0};

        idleInputs();
        doReset();

        @(negedge clk);
        checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'(0));
        checkOutput("reset_req_ready", 32'(bus.req_ready), 32'(0));
        checkOutput("reset_rsp_result", 32'(bus.rsp_result), 32'(0));
        checkOutput("reset_rsp_id", 32'(bus.rsp_id), 32'(0));
        checkZero("reset_rsp_zero", 1'b0);
        @(posedge clk); #1;

        $display("[TB] vector table");
        for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);

        $display("[TB] both requesters continuously valid");
        doReset();
        bus.req_valid = 2'b11;
        bus.req_op[0] = 2'b01; bus.req_a[0] = 4'b1110; bus.req_b[0] = 4'b1011;
        bus.req_op[1] = 2'b10; bus.req_a[1] = 4'b1011; bus.req_b[1] = 4'b1100;
        bus.rsp_ready = 1'b1;
        ng = 0; nr = 0; lastc = -100;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (bus.req_ready != '0) begin
                checkOutput("rr_grant", 32'(bus.req_ready), 32'(1 << (ng % 2)));
                if (ng > 0) checkOutput("rr_spacing", 32'(c - lastc), 32'(3));
                lastc = c;
                ng++;
            end
            if (bus.rsp_valid) begin
                checkOutput("rr_rsp_id", 32'(bus.rsp_id), 32'(nr % 2));
                checkOutput("rr_rsp_result", 32'(bus.rsp_result), (nr % 2 == 0) ? 32'hF : 32'h7);
                nr++;
            end
        end
        checkOutput("rr_grant_count", 32'(ng), 32'(5));
        checkOutput("rr_rsp_count", 32'(nr), 32'(5));
        @(posedge clk); #1;
        idleInputs();
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] response stall");
        bus.req_valid = 2'b01;
        bus.req_op[0] = 2'b11; bus.req_a[0] = 4'b0111; bus.req_b[0] = 4'b1000;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        checkOutput("stall_accept", 32'(bus.req_ready), 32'(1));
        @(posedge clk); #1;
        bus.req_valid = 2'b10;
        bus.req_op[1] = 2'b00; bus.req_a[1] = 4'b1100; bus.req_b[1] = 4'b0110;
        @(negedge clk);
        checkOutput("stall_exec_ready", 32'(bus.req_ready), 32'(0));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("stall_hold_valid", 32'(bus.rsp_valid), 32'(1));
            checkOutput("stall_hold_result", 32'(bus.rsp_result), 32'hF);
            checkOutput("stall_hold_id", 32'(bus.rsp_id), 32'(0));
            checkOutput("stall_hold_ready", 32'(bus.req_ready), 32'(0));
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("stall_release_valid", 32'(bus.rsp_valid), 32'(1));
        checkOutput("stall_release_ready", 32'(bus.req_ready), 32'(0));
        @(negedge clk);
        checkOutput("stall_next_grant", 32'(bus.req_ready), 32'(2));
        checkOutput("stall_next_valid", 32'(bus.rsp_valid), 32'(0));
        @(posedge clk); #1;
        bus.req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("stall_req1_result", 32'(bus.rsp_result), 32'h4);
        checkOutput("stall_req1_id", 32'(bus.rsp_id), 32'(1));
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] reset during hold");
        bus.req_valid = 2'b01;
        bus.req_op[0] = 2'b10; bus.req_a[0] = 4'b0011; bus.req_b[0] = 4'b0101;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        checkOutput("rsthold_accept", 32'(bus.req_ready), 32'(1));
        @(posedge clk); #1;
        bus.req_valid = 2'b10;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rsthold_valid", 32'(bus.rsp_valid), 32'(1));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.req_valid = 2'b11;
        @(negedge clk);
        checkOutput("rsthold_rsp_valid", 32'(bus.rsp_valid), 32'(0));
        checkOutput("rsthold_rsp_result", 32'(bus.rsp_result), 32'(0));
        checkOutput("rsthold_first_grant", 32'(bus.req_ready), 32'(1));
        @(posedge clk); #1;
        idleInputs();
        repeat (4) @(posedge clk);
        #1;

        $display("[TB] randomized run against model");
        doReset();
        for (int i = 0; i < NUM_REQ; i++) begin
            pv[i] = 1'b0; pa[i] = '0; pb[i] = '0; po[i] = '0;
        end
        last_ptr    = NUM_REQ - 1;
        outstanding = 1'b0;
        acc_c       = 0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pv[i] && $urandom_range(0, 2) != 0) begin
                    pv[i] = 1'b1;
                    pa[i] = 4'($urandom_range(0, 15));
                    pb[i] = 4'($urandom_range(0, 15));
                    po[i] = 2'($urandom_range(0, 3));
                end
                bus.req_valid[i] = pv[i];
                bus.req_a[i]     = pa[i];
                bus.req_b[i]     = pb[i];
                bus.req_op[i]    = po[i];
            end
            rr_drv        = ($urandom_range(0, 3) != 0);
            bus.rsp_ready = rr_drv;
            @(negedge clk);
            was_out = outstanding;
            eg      = -1;
            if (!was_out) begin
                for (int k = 1; k <= NUM_REQ; k++) begin
                    idx = (last_ptr + k) % NUM_REQ;
                    if (eg < 0 && pv[idx]) eg = idx;
                end
            end
            checkOutput("rand_req_ready", 32'(bus.req_ready), (eg >= 0) ? 32'(1 << eg) : 32'(0));
            ev = was_out && (c >= acc_c + 2);
            checkOutput("rand_rsp_valid", 32'(bus.rsp_valid), 32'(ev));
            if (ev && q.size() > 0) begin
                e = q[0];
                checkOutput("rand_rsp_id", 32'(bus.rsp_id), 32'(e.id));
                checkOutput("rand_rsp_result", 32'(bus.rsp_result), 32'(e.res));
                checkZero("rand_rsp_zero", e.res == 4'b0000);
                if (rr_drv) begin
                    void'(q.pop_front());
                    outstanding = 1'b0;
                end
            end
            if (eg >= 0) begin
                q.push_back('{eg, refOp(po[eg], pa[eg], pb[eg])});
                last_ptr    = eg;
                pv[eg]      = 1'b0;
                outstanding = 1'b1;
                acc_c       = c;
            end
            @(posedge clk); #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/logic_unit_arbiter.md
# logic_unit_arbiter

- Shares a single registered 4-bit bitwise logic unit (AND/OR/XOR/NAND) among `NUM_REQ` requesters.
- Arbitrates round-robin and accepts one operation at a time.
- Computes the result in a dedicated execute cycle and returns it tagged with the requester ID over a valid/ready response channel.
- Sits between the operand-producing control blocks and the result consumer, and is the single owner of the shared logic datapath.

## Interface
- `WIDTH`, 4, operand/result width in bits
- `NUM_REQ`, 2, number of requesters (≥2)
- `ID_W`, $clog2(NUM_REQ), requester ID width
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `req_valid`  in  NUM_REQ  per-requester request valid
- `req_ready`  out  NUM_REQ  per-requester accept strobe, one-hot or zero
- `req_a`  in  NUM_REQ×WIDTH  operand A per requester
- `req_b`  in  NUM_REQ×WIDTH  operand B per requester
- `req_op`  in  NUM_REQ×2  opcode per requester: 00 AND, 01 OR, 10 XOR, 11 NAND
- `rsp_valid`  out  1  response valid
- `rsp_ready`  in  1  consumer ready
- `rsp_id`  out  ID_W  index of the requester that owns the response
- `rsp_result`  out  WIDTH  operation result
- `rsp_zero`  out  1  result-is-zero flag; present only with `LOGIC_ARB_ZERO_FLAG_EN`

## Operation
- FSM states: IDLE, EXEC, HOLD.
- **IDLE:** if any `req_valid` is set, grant g = first set bit searching upward (with wrap) from `last_grant+1`.
  - `req_ready[g]` is asserted combinationally this cycle.
  - On the edge: latch `req_a[g]`, `req_b[g]`, `req_op[g]` and g; set `last_grant` = g; go to EXEC.
  - No valid request: stay in IDLE with `req_ready` = 0.
- **EXEC:**
  - `rsp_result` ← op(A, B), masked to WIDTH.
  - `rsp_id` ← g; `rsp_valid` ← 1.
  - Go to HOLD.
- **HOLD:** `rsp_valid`, `rsp_id` and `rsp_result` are held stable. When `rsp_valid & rsp_ready`, clear `rsp_valid` on the edge and go to IDLE.
- `req_ready` is 0 in EXEC and HOLD. At most one bit of `req_ready` is ever set.
- Requester rule: `req_valid` and its operands stay stable until `req_ready` is seen. The block never drops a granted request except on reset.
- Opcode decode is total: all four codes are defined, with no illegal encodings.
- Reset values: state IDLE; `last_grant` = NUM_REQ-1, so requester 0 wins first; `rsp_valid` 0; `rsp_result` 0; `rsp_id` 0; `req_ready` 0; `rsp_zero` 0.
- Reset in EXEC or HOLD aborts the operation and discards the response. Reset wins over a simultaneous `rsp_ready` or new request.

## Timing
- Request accepted at edge T (IDLE, `req_valid[g] & req_ready[g]`).
- `rsp_valid` goes high after edge T+1.
- With `rsp_ready` held high, the response completes at edge T+2 and the next accept is at T+3.
- Minimum initiation interval: 3 cycles. Each `rsp_ready` stall cycle in HOLD adds 1.
- A request arriving during EXEC/HOLD waits. It is evaluated in the first IDLE cycle.
- Round-robin fairness: a continuously requesting requester is granted within NUM_REQ grants.

## Configuration
- `LOGIC_ARB_ZERO_FLAG_EN` defined:
  - The `rsp_zero` port exists.
  - Registered in EXEC as (result == 0) and held with the response; reset 0.
- Undefined: the `rsp_zero` port and its register are absent. All other behaviour is identical.

## Structure
- Package `logic_arb_pkg`:
  - `logic_op_e` enum: AND, OR, XOR, NAND.
  - `arb_state_e` enum: IDLE, EXEC, HOLD.
- Sub-module `rr_arbiter`:
  - Inputs: `req`, `last_grant`.
  - Outputs: combinational one-hot `grant`, `grant_id`, `any_req`.
  - Parameter: NUM_REQ.
- Top module: FSM, operand/opcode registers, op decode, response registers.

## Test plan
- Reset, then req0 AND A=1000 B=1010 with `rsp_ready`=1:
  - `req_ready[0]` seen in the first cycle.
  - `rsp_valid` appears 2 cycles later with `rsp_result`=1000, `rsp_id`=0.
- Both requesters valid continuously:
  - req0 OR 1110|1011, req1 XOR 1011^1100.
  - Grants alternate 0,1,0,1; results 1111 (id 0) and 0111 (id 1); 3-cycle spacing.
- NAND A=0111 B=1000 with `rsp_ready`=0 for 4 cycles:
  - `rsp_result`=1111, `rsp_id` stable while held.
  - `req_ready` stays 0 until 1 cycle after `rsp_ready` rises.
- Reset asserted in HOLD with a pending req1:
  - Next cycle `rsp_valid`=0 and state is IDLE.
  - The first grant after reset goes to req0 if both requesters are valid.
- With the macro defined, AND 0101&1010:
  - `rsp_result`=0000, `rsp_zero`=1.
  - The following OR 0101|1010 gives 1111, `rsp_zero`=0.
